// File: rtl/inst_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch
// Purpose  : Instruction prefetch queue between the fetch stage and a
//            combinational instruction ROM. Issues sequential word addresses,
//            buffers {instruction, PC} pairs in a DEPTH-entry FIFO and hands
//            them to the core over a valid/ready handshake. A redirect flushes
//            the queue and restarts fetching at the (word-aligned) target.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH          FIFO entries, power of two, >= 2
//   RESET_PC       first fetch address after reset (word aligned)
// Ports
//   clk            clock, rising edge
//   rst            synchronous reset, active-high
//   rom_ce_o       ROM chip enable (high while fetching)
//   rom_addr_o     ROM word address
//   rom_inst_i     ROM data, valid in the same cycle as rom_addr_o
//   inst_o         instruction at the FIFO head (0 when empty)
//   pc_o           PC of inst_o (0 when empty)
//   valid_o        head entry valid
//   ready_i        core accepts the head this cycle
//   redirect_i     flush the queue and refetch from redirect_pc_i
//   redirect_pc_i  redirect target, bits [1:0] ignored
//   stall_cnt_o    (PREFETCH_STAT_EN only) cycles the core was starved
// Configuration
//   PREFETCH_STAT_EN  when defined, adds the stall_cnt_o starvation counter
// ============================================================================
module inst_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
`ifdef PREFETCH_STAT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        fetch_pc;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [31:0]        inst_mem [DEPTH];
  logic [31:0]        pc_mem   [DEPTH];
  logic               push;
  logic               pop;
  logic               not_empty;

  // A redirect cycle never writes: the fetched word belongs to the old path.
  assign push      = (state == S_RUN) & ~redirect_i;
  assign not_empty = (count != '0);
  assign valid_o   = not_empty & ~redirect_i;
  assign pop       = valid_o & ready_i;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // ROM interface depends on state/fetch_pc only, so neither ready_i nor
  // redirect_i has a combinational path to it.
  assign rom_ce_o   = (state == S_RUN);
  assign rom_addr_o = (state == S_RESET) ? 32'h0 : fetch_pc;

  assign inst_o = not_empty ? inst_mem[rd_ptr] : 32'h0;
  assign pc_o   = not_empty ? pc_mem[rd_ptr]   : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RESET;
      fetch_pc <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_i) begin
      state    <= S_RUN;
      fetch_pc <= redirect_pc_i & 32'hFFFF_FFFC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      count <= count_nxt;
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + 32'd4;   // wraps 0xFFFF_FFFC -> 0 silently
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case (state)
        S_RESET: state <= S_RUN;
        S_RUN:   if (count_nxt == FULL) state <= S_STALL;
        S_STALL: if (count_nxt < FULL)  state <= S_RUN;
        default: state <= S_RESET;
      endcase
    end
  end

  // Storage needs no reset: entries are only observable through count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      inst_mem[wr_ptr] <= rom_inst_i;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

`ifdef PREFETCH_STAT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'h0;
    end else if ((state != S_RESET) && !valid_o) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_prefetch
// Purpose  : Self-checking bench for inst_prefetch. A queue-based reference
//            model predicts every output each cycle; directed sections pin the
//            model with hand-computed literals (reset latency, fill/stall,
//            redirect, address wrap, mid-stream reset), then random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_prefetch;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] RPC_A   = 32'h0000_0000;
  localparam logic [31:0] RPC_B   = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        rom_ce,   rom_ce2;
  logic [31:0] rom_addr, rom_addr2;
  logic [31:0] rom_inst, rom_inst2;
  logic [31:0] inst,     inst2;
  logic [31:0] pc,       pc2;
  logic        valid,    valid2;
  logic        ready2    = 1'b1;
  logic        redirect2 = 1'b0;
  logic [31:0] rpc2      = 32'h0;
`ifdef PREFETCH_STAT_EN
  logic [31:0] stall_cnt, stall_cnt2;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  assign rom_inst  = rom_fn(rom_addr);
  assign rom_inst2 = rom_fn(rom_addr2);

  inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC_A)) dut (
    .clk(clk), .rst(rst),
    .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_inst_i(rom_inst),
    .inst_o(inst), .pc_o(pc), .valid_o(valid), .ready_i(ready),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc)
`ifdef PREFETCH_STAT_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC_B)) dut_wrap (
    .clk(clk), .rst(rst),
    .rom_ce_o(rom_ce2), .rom_addr_o(rom_addr2), .rom_inst_i(rom_inst2),
    .inst_o(inst2), .pc_o(pc2), .valid_o(valid2), .ready_i(ready2),
    .redirect_i(redirect2), .redirect_pc_i(rpc2)
`ifdef PREFETCH_STAT_EN
    , .stall_cnt_o(stall_cnt2)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // Queue holds the PCs currently buffered; fetch happens whenever the model
  // has left reset and the queue has room.
  logic [31:0] mq[$];
  logic [31:0] m_fetch;
  logic [31:0] m_stall;
  bit          m_started;
  bit          m_init = 1'b0;

  always @(negedge clk) begin
    logic        e_ce, e_valid;
    logic [31:0] e_addr, e_pc, e_inst;
    e_ce    = m_started && (mq.size() < DEPTH);
    e_addr  = m_started ? m_fetch : 32'h0;
    e_valid = (mq.size() > 0) && !redirect;
    e_pc    = (mq.size() > 0) ? mq[0] : 32'h0;
    e_inst  = (mq.size() > 0) ? rom_fn(mq[0]) : 32'h0;
    if (m_init) begin
      chk("m_ce",    {31'h0, rom_ce}, {31'h0, e_ce});
      chk("m_addr",  rom_addr, e_addr);
      chk("m_valid", {31'h0, valid}, {31'h0, e_valid});
      chk("m_pc",    pc, e_pc);
      chk("m_inst",  inst, e_inst);
`ifdef PREFETCH_STAT_EN
      chk("m_stall", stall_cnt, m_stall);
`endif
    end
    if (rst) begin
      mq.delete();
      m_fetch   = RPC_A;
      m_started = 1'b0;
      m_stall   = 32'h0;
      m_init    = 1'b1;
    end else if (m_init) begin
      if (m_started && !e_valid) m_stall = m_stall + 32'd1;
      if (redirect) begin
        mq.delete();
        m_fetch = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (e_valid && ready) void'(mq.pop_front());
        if (e_ce) begin
          mq.push_back(m_fetch);
          m_fetch = m_fetch + 32'd4;
        end
      end
      m_started = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] issued[$];
    rst = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) cyc();

    // T1 / T4: reset latency and address wrap on the second instance
    rst = 1'b0;
    smp(); chk("t1_c1_ce", {31'h0, rom_ce}, 32'h0); chk("t1_c1_valid", {31'h0, valid}, 32'h0);
    cyc();
    smp(); chk("t1_c2_ce", {31'h0, rom_ce}, 32'h1); chk("t1_c2_addr", rom_addr, 32'h0);
           chk("t4_c2_addr", rom_addr2, 32'hFFFF_FFF8);
    cyc();
    smp(); chk("t1_c3_valid", {31'h0, valid}, 32'h1); chk("t1_c3_pc", pc, 32'h0);
           chk("t1_c3_addr", rom_addr, 32'h4); chk("t4_c3_pc", pc2, 32'hFFFF_FFF8);
    cyc();
    smp(); chk("t4_c4_pc", pc2, 32'hFFFF_FFFC); chk("t4_c4_valid", {31'h0, valid2}, 32'h1);
    cyc();
    smp(); chk("t4_c5_pc", pc2, 32'h0000_0000);
    cyc();
    smp(); chk("t4_c6_pc", pc2, 32'h0000_0004); chk("t4_c6_inst", inst2, 32'h0004_FFFF ^ 32'h5A5A_0F0F);
    cyc();

    // T2: fill with ready low, then drain
    rst = 1'b1; ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      smp();
      if (rom_ce) issued.push_back(rom_addr);
      if (i == 7) chk("t2_stalled_ce", {31'h0, rom_ce}, 32'h0);
      cyc();
    end
    chk("t2_n_issued", 32'(issued.size()), 32'd4);
    for (int i = 0; i < issued.size() && i < 4; i++) chk("t2_issued_addr", issued[i], 32'(i * 4));
    ready = 1'b1;
    smp(); chk("t2_pc0", pc, 32'h0); chk("t2_ce_full", {31'h0, rom_ce}, 32'h0);
    cyc();
    smp(); chk("t2_pc4", pc, 32'h4); chk("t2_resume_addr", rom_addr, 32'h10);
           chk("t2_resume_ce", {31'h0, rom_ce}, 32'h1);
    cyc();
    smp(); chk("t2_pc8", pc, 32'h8); cyc();
    smp(); chk("t2_pcC", pc, 32'hC); cyc();
    smp(); chk("t2_pc10", pc, 32'h10); cyc();

    // T3: redirect on a full queue
    ready = 1'b0;
    repeat (6) cyc();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    smp(); chk("t3_valid_on_redirect", {31'h0, valid}, 32'h0);
    cyc();
    redirect = 1'b0;
    smp(); chk("t3_addr", rom_addr, 32'h100); chk("t3_ce", {31'h0, rom_ce}, 32'h1);
           chk("t3_valid_empty", {31'h0, valid}, 32'h0);
    cyc();
    smp(); chk("t3_head_valid", {31'h0, valid}, 32'h1); chk("t3_head_pc", pc, 32'h100);
           chk("t3_head_inst", inst, 32'h0100_FFFF ^ 32'h5A5A_0F0F);
    cyc();

    // T6: reset pulse with three buffered entries
    rst = 1'b1; cyc();
    rst = 1'b0; repeat (4) cyc();
    smp(); chk("t6_pre_valid", {31'h0, valid}, 32'h1);
    rst = 1'b1; cyc();
    rst = 1'b0;
    smp(); chk("t6_valid", {31'h0, valid}, 32'h0); chk("t6_ce", {31'h0, rom_ce}, 32'h0);
`ifdef PREFETCH_STAT_EN
    chk("t6_stall_cnt", stall_cnt, 32'h0);
`endif
    cyc();
    smp(); chk("t6_restart_addr", rom_addr, RPC_A); cyc();

    // T5: ready toggling every cycle
    for (int i = 0; i < 40; i++) begin
      ready = i[0];
      cyc();
    end

    // Random traffic: ready, redirects and occasional reset
    for (int i = 0; i < 600; i++) begin
      ready       = ($urandom_range(0, 99) < 65);
      redirect    = ($urandom_range(0, 99) < 5);
      redirect_pc = $urandom;
      rst         = ($urandom_range(0, 199) < 2);
      cyc();
    end
    rst = 1'b0; redirect = 1'b0; ready = 1'b1;
    repeat (5) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
